// File: rtl/rram_pkg.sv
// Shared types and constants for the RRAM host sequencer: op codes, FSM states
// and the latched request payload.
package rram_pkg;

  typedef enum logic [1:0] {
    OP_CMD_ONLY = 2'd0,
    OP_WRITE    = 2'd1,
    OP_READ     = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CE_SU   = 4'd1,
    ST_CMD0    = 4'd2,
    ST_ADDR    = 4'd3,
    ST_WDATA   = 4'd4,
    ST_RDATA   = 4'd5,
    ST_CMD1    = 4'd6,
    ST_WAIT_RB = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

  localparam logic [3:0] CMD_FORM0 = 4'b0111;
  localparam logic [3:0] CMD_FORM1 = 4'b0110;

  typedef struct packed {
    op_e        op;
    logic [3:0] cmd0;
    logic [3:0] cmd1;
    logic       has_cmd1;
    logic       wdata;
  } req_t;

  // Reserved op behaves like CMD_ONLY, so only WRITE and READ carry an address.
  function automatic logic op_has_addr(input op_e op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/rram_nib_strobe.sv
// One nibble cycle: SETUP_CYC cycles WE low, one cycle WE high, HOLD_CYC cycles WE low.
// start_c in the cycle before the nibble cycle aligns cnt_q/we with its first cycle.
module rram_nib_strobe #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_c,
  output logic we,
  output logic done_c
);

  localparam int unsigned LEN = SETUP_CYC + 1 + HOLD_CYC;
  localparam int unsigned CW  = $clog2(LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          we_q, we_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    done_c   = active_q && (cnt_q == CW'(LEN - 1));
    if (start_c) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (done_c) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    we_d = active_d && (cnt_d == CW'(SETUP_CYC));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      we_q     <= we_d;
    end
  end

  assign we = we_q;

endmodule

// File: rtl/rram_host_seq.sv
// Host-side RRAM command sequencer: latches a request, then walks CE/CMD0/ADDR/DATA/CMD1
// and waits for RB. Pin registers are loaded from the next state so they line up with state_q.
module rram_host_seq
  import rram_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned RB_TIMEOUT = 8192,
  parameter int unsigned ADDR_NIB   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [3:0]            req_cmd0,
  input  logic [3:0]            req_cmd1,
  input  logic                  req_has_cmd1,
  input  logic [4*ADDR_NIB-1:0] req_addr,
  input  logic                  req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  CE,
  output logic                  CLE,
  output logic                  ALE,
  output logic                  WE,
  output logic                  RE,
  output logic [3:0]            io_out,
  output logic                  io_oe,
  output logic                  din_out,
  output logic                  din_oe,
  input  logic                  din_in,
  input  logic                  RB
);

  localparam int unsigned CNT_MAX = (RB_TIMEOUT > SETUP_CYC + 1) ? RB_TIMEOUT : SETUP_CYC + 1;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned NW      = $clog2(ADDR_NIB + 1);
  localparam int unsigned AW      = 4 * ADDR_NIB;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] nib_q, nib_d;
  req_t          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rdata_q, rdata_d;
  logic          timeout_q, timeout_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          ce_q, ce_d;
  logic          cle_q, cle_d;
  logic          ale_q, ale_d;
  logic          re_q, re_d;
  logic [3:0]    io_out_q, io_out_d;
  logic          io_oe_q, io_oe_d;
  logic          din_out_q, din_out_d;
  logic          din_oe_q, din_oe_d;

  logic          start_c;
  logic          nib_done_c;
  logic          post_data_c;
  logic          nib_we;

  rram_nib_strobe #(
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .start_c (start_c),
    .we      (nib_we),
    .done_c  (nib_done_c)
  );

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nib_d       = nib_q;
    req_d       = req_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;
    start_c     = 1'b0;
    post_data_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d        = ST_CE_SU;
          req_d.op       = op_e'(req_op);
          req_d.cmd0     = req_cmd0;
          req_d.cmd1     = req_cmd1;
          req_d.has_cmd1 = req_has_cmd1;
          req_d.wdata    = req_wdata;
          addr_d         = req_addr;
          rdata_d        = 1'b0;
          timeout_d      = 1'b0;
        end
      end
      ST_CE_SU: begin
        state_d = ST_CMD0;
        start_c = 1'b1;
      end
      ST_CMD0: begin
        if (nib_done_c) begin
          if (op_has_addr(req_q.op)) begin
            state_d = ST_ADDR;
            nib_d   = '0;
            start_c = 1'b1;
          end else begin
            post_data_c = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (nib_done_c) begin
          if (nib_q == NW'(ADDR_NIB - 1)) begin
            nib_d = '0;
            if (req_q.op == OP_WRITE) begin
              state_d = ST_WDATA;
              start_c = 1'b1;
            end else begin
              state_d = ST_RDATA;
              cnt_d   = '0;
            end
          end else begin
            nib_d   = nib_q + NW'(1);
            start_c = 1'b1;
          end
        end
      end
      ST_WDATA: begin
        if (nib_done_c) post_data_c = 1'b1;
      end
      ST_RDATA: begin
        // Last RE-high cycle: capture the device's bit.
        if (cnt_q == CW'(SETUP_CYC)) begin
          rdata_d     = din_in;
          cnt_d       = '0;
          post_data_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CMD1: begin
        if (nib_done_c) begin
          state_d = ST_WAIT_RB;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RB: begin
        if (RB) begin
          state_d   = ST_DONE;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == CW'(RB_TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (post_data_c) begin
      if (req_q.has_cmd1) begin
        state_d = ST_CMD1;
        start_c = 1'b1;
      end else begin
        state_d = ST_WAIT_RB;
        cnt_d   = '0;
      end
    end

    // Pin values for the cycle in which state_d becomes current
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    ce_d        = (state_d == ST_IDLE) || (state_d == ST_DONE);
    cle_d       = (state_d == ST_CMD0) || (state_d == ST_CMD1);
    ale_d       = (state_d == ST_ADDR);
    re_d        = (state_d == ST_RDATA);
    io_oe_d     = cle_d || ale_d;
    din_oe_d    = (state_d == ST_WDATA);
    din_out_d   = din_oe_d && req_q.wdata;
    unique case (state_d)
      ST_CMD0: io_out_d = req_q.cmd0;
      ST_CMD1: io_out_d = req_q.cmd1;
      ST_ADDR: io_out_d = 4'(addr_q >> (4 * nib_d));
      default: io_out_d = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      nib_q       <= '0;
      req_q       <= '0;
      addr_q      <= '0;
      rdata_q     <= 1'b0;
      timeout_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      ce_q        <= 1'b1;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      re_q        <= 1'b0;
      io_out_q    <= 4'h0;
      io_oe_q     <= 1'b0;
      din_out_q   <= 1'b0;
      din_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nib_q       <= nib_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      ce_q        <= ce_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      re_q        <= re_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
      din_out_q   <= din_out_d;
      din_oe_q    <= din_oe_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_timeout = timeout_q;
  assign CE          = ce_q;
  assign CLE         = cle_q;
  assign ALE         = ale_q;
  assign WE          = nib_we;
  assign RE          = re_q;
  assign io_out      = io_out_q;
  assign io_oe       = io_oe_q;
  assign din_out     = din_out_q;
  assign din_oe      = din_oe_q;

endmodule
